seq_divider: RTL and testbench

- Iterative unsigned restoring divider. It is the inverse-operation companion to the combinational byte adder datapath already on the tile.
- Takes a dividend and divisor through a valid/ready request channel, runs one shift-subtract step per clock, and returns quotient and remainder on a valid/ready result channel.
- Instantiated inside the tile top, between the ui_in/uio_in operand pins and uo_out/uio_out.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/seq_divider_step.sv | 31 +++
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // FIXUP is only reachable when the signed option is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FIXUP = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if non-negative.
import seq_divider_pkg::*;

module div_step #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] nxt;
  logic           unused_msb;

  // Trial subtraction is WIDTH+1 wide; the kept value is always < divisor,
  // so its top bit is zero and can be dropped.
  always_comb begin
    shifted    = {rem_in, bit_in};
    trial      = shifted - {1'b0, divisor};
    q_bit      = (shifted >= {1'b0, divisor});
    nxt        = q_bit ? trial : shifted;
    rem_out    = nxt[WIDTH-1:0];
    unused_msb = nxt[WIDTH];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready request and result channels.
// Optional: define SEQ_DIVIDER_SIGNED_EN to add the signed_op input and a
// FIXUP state that restores two's-complement signs after a magnitude divide.
import seq_divider_pkg::*;

module seq_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] work_q, work_d;   // dividend shifts out MSB, quotient bits enter LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             nq_q, nq_d;       // negate quotient in FIXUP
  logic             nr_q, nr_d;       // negate remainder in FIXUP
  logic             dvd_neg, dvs_neg;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (work_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign req_ready   = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dz_q;

  // Operand magnitudes fed into the unsigned core at accept time.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn_d   = sgn_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dz_d = 1'b0;
          if (divisor == '0) begin
            // Divide by zero short-circuits straight to the result.
            state_d = DONE;
            quot_d  = '1;
            remd_d  = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            work_d  = dvd_mag;
            dvs_d   = dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn_d   = signed_op;
            nq_d    = dvd_neg ^ dvs_neg;
            nr_d    = dvd_neg;
`endif
          end
        end
      end
      RUN: begin
        rem_d  = step_rem;
        work_d = {work_q[WIDTH-2:0], step_q};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (sgn_q) begin
            state_d = FIXUP;
          end else begin
            state_d = DONE;
            quot_d  = {work_q[WIDTH-2:0], step_q};
            remd_d  = step_rem;
          end
`else
          state_d = DONE;
          quot_d  = {work_q[WIDTH-2:0], step_q};
          remd_d  = step_rem;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIXUP: begin
        // MIN/-1 falls out naturally: magnitude MIN negates back to MIN.
        state_d = DONE;
        quot_d  = nq_q ? (~work_q + 1'b1) : work_q;
        remd_d  = nr_q ? (~rem_q + 1'b1) : rem_q;
      end
`endif
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sgn_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sgn_q   <= sgn_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic       signed_op;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full transaction. Latency counts edges after the accepting edge
  // until res_valid is seen (0 for divide-by-zero, which is valid right
  // after accept). Operands are scrambled and req_valid kept high after
  // accept to show they are neither re-sampled nor queued.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int hold);
    int   lat;
    logic rr_bad;
    @(negedge clk);
    req_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    res_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    dividend = ~a;
    divisor  = 8'h01;
    lat      = 0;
    rr_bad   = 1'b0;
    while (!res_valid && lat < 40) begin
      if (req_ready) rr_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("req_ready_busy", rr_bad, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    chk("req_ready_done", req_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_valid", res_valid, 0);
    chk("handoff_ready", req_ready, 1);
    chk("kept_quotient", quotient, eq);
    chk("kept_remainder", remainder, er);
    res_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;

    run_op(8'd200, 8'd7,   8, 8'd28,  8'd4,  1'b0, 0);
    run_op(8'd250, 8'd16,  8, 8'd15,  8'd10, 1'b0, 0);
    run_op(8'd255, 8'd255, 8, 8'd1,   8'd0,  1'b0, 3);
    run_op(8'd255, 8'd1,   8, 8'd255, 8'd0,  1'b0, 0);
    run_op(8'd0,   8'd1,   8, 8'd0,   8'd0,  1'b0, 0);
    run_op(8'd7,   8'd9,   8, 8'd0,   8'd7,  1'b0, 0);
    run_op(8'd5,   8'd0,   0, 8'd255, 8'd5,  1'b1, 0);

    // Abort 100/3 after four RUN steps; outputs still hold the 5/0 result.
    @(negedge clk);
    req_valid = 1'b1;
    dividend  = 8'd100;
    divisor   = 8'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_res_valid", res_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    run_op(8'd9, 8'd4, 8, 8'd2, 8'd1, 1'b0, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_op = 1'b1;
    run_op(8'h9C, 8'd7,  9, 8'hF2, 8'hFE, 1'b0, 0);
    run_op(8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0, 0);
    signed_op = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
